// File: rtl/nw_pkg.sv
// nw_pkg: shared state encoding and phase constants for the Needleman-Wunsch fill sequencer
package nw_pkg;
    typedef enum logic [2:0] {IDLE, INIT_ROW, INIT_COL, FILL, DONE} state_t;
    localparam logic [1:0] PH_READ  = 2'd0;
    localparam logic [1:0] PH_CALC  = 2'd1;
    localparam logic [1:0] PH_WRITE = 2'd2;
endpackage

// File: rtl/nw_phase_counter.sv
// nw_phase_counter: mod-3 READ/CALC/WRITE counter; ports clk, rst (async low), en, clr (sync), phase, wrap (WRITE cycle with en)
module nw_phase_counter
    import nw_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       wrap
);
    assign wrap = en && phase == PH_WRITE;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            phase <= PH_READ;
        else if (clr)
            phase <= PH_READ;
        else if (en)
            phase <= wrap ? PH_READ : phase + 2'd1;
    end
endmodule

// File: rtl/nw_fill_controller.sv
// nw_fill_controller: sequences boundary init then row-major READ/CALC/WRITE fill; ports clk, rst (async low), start, stall -> busy, done, init_en, rd_en, calc_en, wr_en, row_idx, col_idx, phase
module nw_fill_controller
    import nw_pkg::*;
#(
    parameter int N_ROWS = 8,
    parameter int N_COLS = 8,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    output logic             busy,
    output logic             done,
    output logic             init_en,
    output logic             rd_en,
    output logic             calc_en,
    output logic             wr_en,
    output logic [IDX_W-1:0] row_idx,
    output logic [IDX_W-1:0] col_idx,
    output logic [1:0]       phase
);
    localparam logic [IDX_W-1:0] LR  = IDX_W'(N_ROWS);
    localparam logic [IDX_W-1:0] LC  = IDX_W'(N_COLS);
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    state_t           state, state_n;
    logic [IDX_W-1:0] row_n, col_n;
    logic             fill_go, wrap;

    assign fill_go = state == FILL && !stall;

    nw_phase_counter u_phase (
        .clk  (clk),
        .rst  (rst),
        .en   (fill_go),
        .clr  (state != FILL),
        .phase(phase),
        .wrap (wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            row_idx <= '0;
            col_idx <= '0;
        end else begin
            state   <= state_n;
            row_idx <= row_n;
            col_idx <= col_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row_idx;
        col_n   = col_idx;
        case (state)
            IDLE: if (start) begin
                state_n = INIT_ROW;
                row_n   = '0;
                col_n   = '0;
            end
            INIT_ROW: if (!stall) begin
                if (col_idx == LC) begin
                    state_n = INIT_COL;
                    row_n   = ONE;
                    col_n   = '0;
                end else
                    col_n = col_idx + ONE;
            end
            INIT_COL: if (!stall) begin
                if (row_idx == LR) begin
                    state_n = FILL;
                    row_n   = ONE;
                    col_n   = ONE;
                end else
                    row_n = row_idx + ONE;
            end
            FILL: if (wrap) begin
                if (col_idx < LC)
                    col_n = col_idx + ONE;
                else if (row_idx < LR) begin
                    row_n = row_idx + ONE;
                    col_n = ONE;
                end else
                    state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
                row_n   = '0;
                col_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Strobes decode the registered state; a stalled cycle issues nothing.
    always_comb begin
        busy    = state != IDLE;
        done    = state == DONE;
        init_en = (state == INIT_ROW || state == INIT_COL) && !stall;
        rd_en   = fill_go && phase == PH_READ;
        calc_en = fill_go && phase == PH_CALC;
        wr_en   = init_en || (fill_go && phase == PH_WRITE);
    end
endmodule

// File: tb/tb_nw_fill_controller.sv
// tb_nw_fill_controller: randomized self-checking bench against an operation-list reference model
module tb_nw_fill_controller;
    logic clk = 0, rst = 0, start = 0, stall = 0, sel = 0;
    always #5 clk = ~clk;

    logic s_busy, s_done, s_init_en, s_rd_en, s_calc_en, s_wr_en;
    logic [3:0] s_row, s_col;
    logic [1:0] s_phase;
    logic b_busy, b_done, b_init_en, b_rd_en, b_calc_en, b_wr_en;
    logic [3:0] b_row, b_col;
    logic [1:0] b_phase;
    logic [15:0] obs;

    nw_fill_controller #(.N_ROWS(2), .N_COLS(2), .IDX_W(4)) u_small (
        .clk(clk), .rst(rst), .start(start & ~sel), .stall(stall),
        .busy(s_busy), .done(s_done), .init_en(s_init_en), .rd_en(s_rd_en),
        .calc_en(s_calc_en), .wr_en(s_wr_en), .row_idx(s_row), .col_idx(s_col), .phase(s_phase)
    );

    nw_fill_controller #(.N_ROWS(8), .N_COLS(8), .IDX_W(4)) u_big (
        .clk(clk), .rst(rst), .start(start & sel), .stall(stall),
        .busy(b_busy), .done(b_done), .init_en(b_init_en), .rd_en(b_rd_en),
        .calc_en(b_calc_en), .wr_en(b_wr_en), .row_idx(b_row), .col_idx(b_col), .phase(b_phase)
    );

    assign obs = sel ? {b_busy, b_done, b_init_en, b_rd_en, b_calc_en, b_wr_en, b_row, b_col, b_phase}
                     : {s_busy, s_done, s_init_en, s_rd_en, s_calc_en, s_wr_en, s_row, s_col, s_phase};

    int n_cmp = 0, n_err = 0;

    typedef struct {int k; int r; int c; int ph;} op_t;
    op_t exp_q[$];
    bit wr_map [0:8][0:8];

    // k: 0 boundary write, 1 read, 2 calc, 3 write, 4 done
    function automatic void build(input int nr, input int nc);
        exp_q.delete();
        for (int c = 0; c <= nc; c++) exp_q.push_back(op_t'{0, 0, c, 0});
        for (int r = 1; r <= nr; r++) exp_q.push_back(op_t'{0, r, 0, 0});
        for (int r = 1; r <= nr; r++)
            for (int c = 1; c <= nc; c++)
                for (int p = 0; p < 3; p++) exp_q.push_back(op_t'{p + 1, r, c, p});
        exp_q.push_back(op_t'{4, 0, 0, 0});
    endfunction

    function automatic logic [15:0] vec(input op_t o, input bit st);
        vec = {1'b1, o.k == 4, o.k == 0 && !st, o.k == 1 && !st, o.k == 2 && !st,
               (o.k == 0 || o.k == 3) && !st, 4'(o.r), 4'(o.c), 2'(o.ph)};
    endfunction

    task automatic run_fill(input bit big, input int pct, input int stall_at, input int stall_len,
                            input int rst_at, input bit noisy,
                            output int unstalled, output int total, output int dones);
        int idx, sl, ri, ci;
        bit st, st_eff;
        logic [15:0] e, m;
        idx = 0; sl = 0; unstalled = 0; total = 0; dones = 0;
        sel = big;
        build(big ? 8 : 2, big ? 8 : 2);
        for (int r = 0; r <= 8; r++) for (int c = 0; c <= 8; c++) wr_map[r][c] = 0;
        @(posedge clk); #1 start = 1; stall = 0;
        @(posedge clk); #1 start = 0;
        while (idx < exp_q.size() && total < 5000) begin
            st = (idx == stall_at && sl < stall_len) || ($urandom_range(99) < pct);
            if (idx == stall_at && st) sl++;
            stall = st;
            start = noisy ? (exp_q[idx].k == 4 ? 1'b1 : 1'($urandom_range(1))) : 1'b0;
            if (idx == rst_at) begin
                rst = 0; start = 0; stall = 0;
                #1;
                n_cmp++;
                if (obs !== 16'h0) begin n_err++; $display("FAIL async_reset got=%h exp=0000", obs); end
                @(posedge clk); #1 rst = 1;
                @(negedge clk);
                n_cmp++;
                if (obs !== 16'h0) begin n_err++; $display("FAIL post_reset_idle got=%h exp=0000", obs); end
                return;
            end
            @(negedge clk);
            st_eff = st && exp_q[idx].k != 4;
            e = vec(exp_q[idx], st_eff);
            m = exp_q[idx].k == 4 ? 16'hFC00 : 16'hFFFF;
            n_cmp++;
            if ((obs & m) !== (e & m)) begin
                n_err++;
                $display("FAIL seq idx=%0d cyc=%0d got=%h exp=%h", idx, total, obs & m, e & m);
            end
            if (obs[10] === 1'b1) begin
                ri = int'(obs[9:6]); ci = int'(obs[5:2]);
                if (obs[13] !== 1'b1) begin
                    n_cmp++;
                    if (ri < 1 || ci < 1 || ri > 8 || ci > 8 || wr_map[ri][ci] ||
                        !wr_map[ri-1][ci-1] || !wr_map[ri-1][ci] || !wr_map[ri][ci-1]) begin
                        n_err++;
                        $display("FAIL scoreboard cell=(%0d,%0d) got=bad_order exp=first_write_after_neighbours", ri, ci);
                    end
                end
                if (ri <= 8 && ci <= 8) wr_map[ri][ci] = 1;
            end
            if (obs[14] === 1'b1) dones++;
            if (!st_eff) begin unstalled++; idx++; end
            total++;
            @(posedge clk); #1;
        end
        stall = 0; start = 0;
        n_cmp++;
        if (idx != exp_q.size()) begin n_err++; $display("FAIL timeout got_ops=%0d exp_ops=%0d", idx, exp_q.size()); end
        @(negedge clk);
        n_cmp++;
        if (obs[15:14] !== 2'b00) begin n_err++; $display("FAIL idle_after_done got=%b exp=00", obs[15:14]); end
    endtask

    task automatic test_reset;
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 start = ~start; sel = i[0];
            @(negedge clk);
            n_cmp++;
            if (obs !== 16'h0) begin n_err++; $display("FAIL reset_hold got=%h exp=0000", obs); end
        end
        @(posedge clk); #1 rst = 1; start = 0;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            @(negedge clk);
            n_cmp++;
            if (obs !== 16'h0) begin n_err++; $display("FAIL reset_idle got=%h exp=0000", obs); end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_run(input string name, input int u, input int t, input int d,
                             input int eu, input int et);
        n_cmp++;
        if (u !== eu || t !== et || d !== 1) begin
            n_err++;
            $display("FAIL %s got=u%0d/t%0d/d%0d exp=u%0d/t%0d/d1", name, u, t, d, eu, et);
        end
    endtask

    task automatic test_basic;
        int u, t, d;
        run_fill(0, 0, -1, 0, -1, 0, u, t, d);
        check_run("basic", u, t, d, 18, 18);
    endtask

    task automatic test_stall;
        int u, t, d;
        run_fill(0, 0, 9, 5, -1, 0, u, t, d);
        check_run("stall_calc", u, t, d, 18, 23);
    endtask

    task automatic test_start_ignored;
        int u, t, d;
        run_fill(0, 0, -1, 0, -1, 1, u, t, d);
        check_run("start_ignored", u, t, d, 18, 18);
    endtask

    task automatic test_reset_mid_fill;
        int u, t, d;
        run_fill(0, 0, -1, 0, 11, 0, u, t, d);
        n_cmp++;
        if (d !== 0) begin n_err++; $display("FAIL reset_no_done got=%0d exp=0", d); end
        run_fill(0, 0, -1, 0, -1, 0, u, t, d);
        check_run("restart", u, t, d, 18, 18);
    endtask

    task automatic test_random_big;
        int u, t, d, cnt;
        run_fill(1, 30, -1, 0, -1, 1, u, t, d);
        n_cmp++;
        if (u !== 210 || d !== 1) begin n_err++; $display("FAIL big_unstalled got=%0d/d%0d exp=210/d1", u, d); end
        cnt = 0;
        for (int r = 1; r <= 8; r++) for (int c = 1; c <= 8; c++) cnt += int'(wr_map[r][c]);
        n_cmp++;
        if (cnt !== 64) begin n_err++; $display("FAIL big_coverage got=%0d exp=64", cnt); end
        run_fill(0, 30, -1, 0, -1, 0, u, t, d);
        n_cmp++;
        if (u !== 18 || d !== 1) begin n_err++; $display("FAIL small_random got=%0d/d%0d exp=18/d1", u, d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_ignored();
        test_reset_mid_fill();
        test_random_big();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
